// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, frame timing, R/W encoding and FSM states
// for the SPI read responder.
package spi_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = 5;
    // rising edge on which the address is complete
    localparam int ADDR_DONE  = 1 + ADDR_W;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DONE,
        IGNORE
    } spi_state_e;

endpackage

// File: rtl/spi_frame_counter.sv
// spi_frame_counter: 5-bit saturating count of SCLK rising edges in a frame,
// cleared asynchronously by rst_n low or nCS high.
module spi_frame_counter
    import spi_pkg::*;
(
    input  logic             SCLK,
    input  logic             rst_n,
    input  logic             nCS,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(FRAME_BITS);

    logic clr_n;

    assign clr_n = rst_n & ~nCS;

    always_ff @(posedge SCLK or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en && count != SAT) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_read_responder.sv
// spi_read_responder: serial register read target, COPI sampled on SCLK rise,
// CIPO launched on SCLK fall. Option SPI_RD_ERR_FLAG_EN: 0xFF + sticky rd_err.
module spi_read_responder
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 5
) (
    input  logic              rst_n,
    input  logic              SCLK,
    input  logic              nCS,
    input  logic              COPI,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] data3,
    input  logic [DATA_W-1:0] data4,
    output logic              CIPO,
    output logic              cipo_oe,
    output logic              rd_done,
    output logic              rd_err
);

    localparam int NUM_EFF = (NUM_REGS < 5) ? NUM_REGS : 5;

`ifdef SPI_RD_ERR_FLAG_EN
    localparam logic [DATA_W-1:0] INV_VAL = '1;
`else
    localparam logic [DATA_W-1:0] INV_VAL = '0;
`endif

    logic              clr_n;
    logic              armed;
    logic [CNT_W-1:0]  count;
    spi_state_e        state_q;
    spi_state_e        state_d;
    logic              rw_q;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] full_addr;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] sel_val;
    logic              addr_ok;
    logic              load;

    assign clr_n = rst_n & ~nCS;

    // A frame may only start after a fresh nCS falling edge, so a reset
    // released mid-frame leaves the rest of that frame ignored.
    always_ff @(negedge nCS or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    spi_frame_counter u_cnt (
        .SCLK  (SCLK),
        .rst_n (rst_n),
        .nCS   (nCS),
        .en    (armed),
        .count (count)
    );

    assign full_addr = {addr_q[ADDR_W-2:0], COPI};
    assign addr_ok   = full_addr < ADDR_W'(NUM_EFF);
    assign load      = (state_q == ADDR) &&
                       (count == CNT_W'(ADDR_DONE - 1));

    always_comb begin
        sel_val = '0;
        case (full_addr)
            7'd0:    sel_val = data0;
            7'd1:    sel_val = data1;
            7'd2:    sel_val = data2;
            7'd3:    sel_val = data3;
            7'd4:    sel_val = data4;
            default: sel_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (armed) state_d = CMD;
            end
            CMD: begin
                unique case (rw_q)
                    RW_READ:  state_d = ADDR;
                    RW_WRITE: state_d = IGNORE;
                    default:  state_d = IGNORE;
                endcase
            end
            ADDR: begin
                if (load) state_d = DATA;
            end
            DATA: begin
                if (count == CNT_W'(FRAME_BITS - 1)) state_d = DONE;
            end
            DONE:    state_d = DONE;
            IGNORE:  state_d = IGNORE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SCLK or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && armed) rw_q <= COPI;
            if (count != '0 && count < CNT_W'(ADDR_DONE)) addr_q <= full_addr;
            // shift after each controller sample so the next fall sees the next bit
            if (load) begin
                shift_q <= addr_ok ? sel_val : INV_VAL;
                valid_q <= addr_ok;
            end else if (state_q == DATA) begin
                shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(negedge SCLK or negedge clr_n) begin
        if (!clr_n) begin
            CIPO    <= 1'b0;
            cipo_oe <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            CIPO    <= 1'b0;
            cipo_oe <= 1'b0;
            if (state_q == DATA) begin
                CIPO    <= shift_q[DATA_W-1];
                cipo_oe <= 1'b1;
            end
            if (state_q == DONE) rd_done <= valid_q;
        end
    end

`ifdef SPI_RD_ERR_FLAG_EN
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_err <= 1'b0;
        end else if (load && !addr_ok) begin
            rd_err <= 1'b1;
        end
    end
`else
    assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_read_responder.sv
// tb_spi_read_responder: vector table, corner sequences and random frames
// checked against a register-array read model.
module tb_spi_read_responder;

    localparam int NREGS = 5;
`ifdef SPI_RD_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [7:0] INV = ERR_EN ? 8'hFF : 8'h00;

    logic       SCLK  = 1'b0;
    logic       rst_n = 1'b1;
    logic       nCS   = 1'b1;
    logic       COPI  = 1'b0;
    logic [7:0] regs [5];
    logic [7:0] data0, data1, data2, data3, data4;
    logic       CIPO, cipo_oe, rd_done, rd_err;

    int   checks = 0;
    int   errors = 0;
    logic err_exp = 1'b0;

    assign data0 = regs[0];
    assign data1 = regs[1];
    assign data2 = regs[2];
    assign data3 = regs[3];
    assign data4 = regs[4];

    spi_read_responder #(.NUM_REGS(NREGS)) dut (
        .rst_n   (rst_n),
        .SCLK    (SCLK),
        .nCS     (nCS),
        .COPI    (COPI),
        .data0   (data0),
        .data1   (data1),
        .data2   (data2),
        .data3   (data3),
        .data4   (data4),
        .CIPO    (CIPO),
        .cipo_oe (cipo_oe),
        .rd_done (rd_done),
        .rd_err  (rd_err)
    );

    always #5 SCLK = ~SCLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input int a);
        if (a < NREGS) return regs[a];
        return INV;
    endfunction

    task automatic run_frame(input logic rw, input logic [6:0] a,
                             input logic [7:0] wd, input int abort_at,
                             input int rst_at, input bit mutate,
                             output logic [7:0] rx, output int oe_cnt,
                             output logic done);
        logic [15:0] bits;
        bits   = {rw, a, wd};
        rx     = '0;
        oe_cnt = 0;
        done   = 1'b0;
        @(negedge SCLK);
        #1 nCS = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            COPI = bits[15];
            bits = bits << 1;
            @(posedge SCLK);
            if (k == abort_at) begin
                #1 nCS = 1'b1;
                #1;
                check("abort_oe", 32'(cipo_oe), 0);
                check("abort_cipo", 32'(CIPO), 0);
                check("abort_done", 32'(rd_done), 0);
                return;
            end
            if (k == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_oe", 32'(cipo_oe), 0);
                check("rst_cipo", 32'(CIPO), 0);
                check("rst_done", 32'(rd_done), 0);
                check("rst_err", 32'(rd_err), 0);
                #2 rst_n = 1'b1;
                oe_cnt  = 0;
                err_exp = 1'b0;
            end
            if (mutate && k == 8) #1 regs[0] = 8'hEE;
            @(negedge SCLK);
            #1;
            if (cipo_oe) oe_cnt++;
            if (k >= 8 && k <= 15) rx = {rx[6:0], CIPO};
        end
        repeat (2) begin
            @(negedge SCLK);
            #1;
            if (cipo_oe) oe_cnt++;
        end
        done = rd_done;
        nCS  = 1'b1;
        #1;
        check("ncs_clears_done", 32'(rd_done), 0);
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] a;
        logic [7:0] wd;
        logic [7:0] exp_rx;
        int         exp_oe;
        logic       exp_done;
    } vec_t;

    vec_t       vt [8];
    logic [7:0] rx;
    int         oe;
    logic       done;
    logic       rw;
    logic [6:0] a;
    logic [7:0] wd;
    logic [7:0] exp;

    task automatic post_frame(input string tag, input logic r,
                              input logic [6:0] ad, input logic [7:0] e_rx,
                              input int e_oe, input logic e_done);
        if (!r) check({tag, "_rx"}, 32'(rx), 32'(e_rx));
        check({tag, "_oe"}, 32'(oe), 32'(e_oe));
        check({tag, "_done"}, 32'(done), 32'(e_done));
        if (ERR_EN && !r && int'(ad) >= NREGS) err_exp = 1'b1;
        check({tag, "_err"}, 32'(rd_err), 32'(err_exp));
    endtask

    initial begin
        regs[0] = 8'h11;
        regs[1] = 8'hC3;
        regs[2] = 8'hA5;
        regs[3] = 8'h3C;
        regs[4] = 8'h5A;
        vt[0] = '{1'b0, 7'd2,   8'h00, 8'hA5, 8, 1'b1};
        vt[1] = '{1'b1, 7'd1,   8'h3C, 8'h00, 0, 1'b0};
        vt[2] = '{1'b0, 7'd7,   8'h00, INV,   8, 1'b0};
        vt[3] = '{1'b0, 7'd0,   8'h00, 8'h11, 8, 1'b1};
        vt[4] = '{1'b0, 7'd4,   8'h00, 8'h5A, 8, 1'b1};
        vt[5] = '{1'b0, 7'd5,   8'h00, INV,   8, 1'b0};
        vt[6] = '{1'b0, 7'd127, 8'hFF, INV,   8, 1'b0};
        vt[7] = '{1'b0, 7'd1,   8'h00, 8'hC3, 8, 1'b1};

        #2 rst_n = 1'b0;
        #1;
        check("reset_cipo", 32'(CIPO), 0);
        check("reset_oe", 32'(cipo_oe), 0);
        check("reset_done", 32'(rd_done), 0);
        check("reset_err", 32'(rd_err), 0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_frame(vt[i].rw, vt[i].a, vt[i].wd, 0, 0, 1'b0, rx, oe, done);
            post_frame($sformatf("vec%0d", i), vt[i].rw, vt[i].a,
                       vt[i].exp_rx, vt[i].exp_oe, vt[i].exp_done);
        end

        run_frame(1'b0, 7'd0, 8'h00, 0, 0, 1'b1, rx, oe, done);
        post_frame("snapshot", 1'b0, 7'd0, 8'h11, 8, 1'b1);
        regs[0] = 8'h11;

        run_frame(1'b0, 7'd2, 8'h00, 11, 0, 1'b0, rx, oe, done);
        run_frame(1'b0, 7'd4, 8'h00, 0, 0, 1'b0, rx, oe, done);
        post_frame("after_abort", 1'b0, 7'd4, 8'h5A, 8, 1'b1);

        run_frame(1'b0, 7'd3, 8'h00, 0, 12, 1'b0, rx, oe, done);
        check("rst_hold_oe", 32'(oe), 0);
        check("rst_hold_done", 32'(done), 0);
        check("rst_hold_err", 32'(rd_err), 0);
        run_frame(1'b0, 7'd1, 8'h00, 0, 0, 1'b0, rx, oe, done);
        post_frame("after_rst", 1'b0, 7'd1, 8'hC3, 8, 1'b1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 5; i++) regs[i] = 8'($urandom);
            rw = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) a = 7'($urandom_range(0, 127));
            else a = 7'($urandom_range(0, 7));
            wd  = 8'($urandom);
            exp = model_read(int'(a));
            run_frame(rw, a, wd, 0, 0, 1'b0, rx, oe, done);
            post_frame($sformatf("rnd%0d", n), rw, a, exp,
                       rw ? 0 : 8, !rw && (int'(a) < NREGS));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
